// File: rtl/proj_001.sv
// Two-operand serial adder: a start strobe marks operand A on din, the next
// sample is operand B, and the 5-bit sum is returned with a one-cycle valid pulse.
module proj_001 (
  input  logic       clock,
  input  logic       reset,
  input  logic [3:0] din,
  input  logic       start,
  output logic [4:0] result,
  output logic       valid
);

  typedef enum logic {
    IDLE  = 1'b0,
    GET_B = 1'b1
  } state_t;

  state_t     r_state;
  logic [3:0] r_a;
  logic [4:0] r_result;
  logic       r_valid;
  logic [4:0] w_sum;

  assign w_sum = {1'b0, r_a} + {1'b0, din};

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state  <= IDLE;
      r_a      <= 4'd0;
      r_result <= 5'd0;
      r_valid  <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_a     <= din;
            r_state <= GET_B;
          end
        end
        GET_B: begin
          // start is deliberately ignored here: this sample is always operand B.
          r_result <= w_sum;
          r_valid  <= 1'b1;
          r_state  <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign result = r_result;
  assign valid  = r_valid;

endmodule

// File: tb/tb_proj_001.sv
// Scoreboard bench for proj_001: stimulus pushes hand-computed sums, a negedge
// monitor pops and compares them whenever valid is seen.
module tb_proj_001;

  logic       clock;
  logic       reset;
  logic [3:0] din;
  logic       start;
  logic [4:0] result;
  logic       valid;

  int checks = 0;
  int errors = 0;
  logic [4:0] exp_q[$];
  logic prev_valid = 1'b0;
  int   txn = 0;

  proj_001 dut (
    .clock (clock),
    .reset (reset),
    .din   (din),
    .start (start),
    .result(result),
    .valid (valid)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Monitor: every valid must match the oldest expected sum, and never last two cycles.
  always @(negedge clock) begin
    if (valid) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_valid: result=%0d with no sum expected", result);
      end else begin
        logic [4:0] e;
        e = exp_q.pop_front();
        txn++;
        if (result !== e) begin
          errors++;
          $display("FAIL sum_%0d: result=%0d expected=%0d", txn, result, e);
        end else begin
          $display("txn %0d: result=%0d expected=%0d ok", txn, result, e);
        end
      end
      if (prev_valid) begin
        checks++;
        errors++;
        $display("FAIL valid_width: valid high for two consecutive cycles");
      end
    end
    prev_valid = valid;
  end

  task automatic step(input logic rst, input logic st, input logic [3:0] d);
    reset = rst;
    start = st;
    din   = d;
    @(posedge clock);
    #1;
  endtask

  task automatic check_out(input string name, input logic [4:0] exp_r, input logic exp_v);
    checks++;
    if (result !== exp_r || valid !== exp_v) begin
      errors++;
      $display("FAIL %s: result=%0d valid=%0b expected result=%0d valid=%0b",
               name, result, valid, exp_r, exp_v);
    end else begin
      $display("%s: result=%0d valid=%0b ok", name, result, valid);
    end
  endtask

  task automatic frame(input logic [3:0] a, input logic [3:0] b, input logic [4:0] exp_sum);
    exp_q.push_back(exp_sum);
    step(1'b0, 1'b1, a);
    step(1'b0, 1'b0, b);
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    din   = 4'h0;

    // Reset held with start and din active
    step(1'b1, 1'b1, 4'hF);
    check_out("reset_cyc1", 5'd0, 1'b0);
    step(1'b1, 1'b1, 4'hF);
    check_out("reset_cyc2", 5'd0, 1'b0);
    step(1'b0, 1'b0, 4'h0);
    check_out("post_reset_idle", 5'd0, 1'b0);
    step(1'b0, 1'b0, 4'hA);
    check_out("idle_din_ignored", 5'd0, 1'b0);

    // Single computation 3+5, then result holds while idle
    frame(4'd3, 4'd5, 5'd8);
    check_out("single_valid", 5'd8, 1'b1);
    step(1'b0, 1'b0, 4'h7);
    check_out("single_hold1", 5'd8, 1'b0);
    step(1'b0, 1'b0, 4'h2);
    check_out("single_hold2", 5'd8, 1'b0);

    // Max and zero operands
    frame(4'd15, 4'd15, 5'd30);
    check_out("max_sum", 5'd30, 1'b1);
    frame(4'd0, 4'd0, 5'd0);
    check_out("zero_sum", 5'd0, 1'b1);
    step(1'b0, 1'b0, 4'h0);

    // Back-to-back frames, start every second cycle
    frame(4'd1, 4'd2, 5'd3);
    frame(4'd7, 4'd9, 5'd16);
    check_out("b2b_second", 5'd16, 1'b1);
    frame(4'd15, 4'd1, 5'd16);
    step(1'b0, 1'b0, 4'h0);
    check_out("b2b_after", 5'd16, 1'b0);

    // start during GET_B is treated as operand B only
    exp_q.push_back(5'd10);
    step(1'b0, 1'b1, 4'd4);
    step(1'b0, 1'b1, 4'd6);
    check_out("start_in_getb", 5'd10, 1'b1);
    step(1'b0, 1'b0, 4'd0);
    check_out("start_in_getb_next", 5'd10, 1'b0);
    step(1'b0, 1'b0, 4'd0);
    check_out("start_in_getb_idle", 5'd10, 1'b0);

    // Reset mid-frame discards A and produces no valid
    step(1'b0, 1'b1, 4'd9);
    step(1'b1, 1'b0, 4'd3);
    check_out("midframe_reset", 5'd0, 1'b0);
    step(1'b0, 1'b0, 4'd3);
    check_out("midframe_no_valid", 5'd0, 1'b0);
    frame(4'd2, 4'd2, 5'd4);
    check_out("after_reset_frame", 5'd4, 1'b1);

    repeat (4) step(1'b0, 1'b0, 4'd0);

    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL missing_valids: %0d sums never produced, expected 0", exp_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
